// File: rtl/uart_alu_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_alu_ctrl_pkg
// Description : Shared defaults and state encoding for the UART/ALU sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_alu_ctrl_pkg;

    localparam int NB_DATA_DEF       = 8;
    localparam int NB_OP_DEF         = 6;
    localparam int NB_TIMEOUT_DEF    = 12;
    localparam int TIMEOUT_TICKS_DEF = 2048;
    localparam int NB_STATE          = 3;

    typedef enum logic [NB_STATE-1:0] {
        S_IDLE    = 3'd0,
        S_WAIT_B  = 3'd1,
        S_WAIT_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_SEND    = 3'd4,
        S_WAIT_TX = 3'd5
    } state_t;

    // Inter-byte timeout runs only while a frame is partially received.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_WAIT_B) || (s == S_WAIT_OP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_alu_ctrl_tick_timeout.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_alu_ctrl_tick_timeout
// Description : Baud-tick counter with clear/enable and a combinational expiry.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_alu_ctrl_tick_timeout #(
    parameter int NB_TIMEOUT    = 12,
    parameter int TIMEOUT_TICKS = 2048
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [NB_TIMEOUT-1:0] C_LAST = NB_TIMEOUT'(TIMEOUT_TICKS - 1);

    logic [NB_TIMEOUT-1:0] r_count;

    assign o_expire = i_enable && i_tick && (r_count == C_LAST);

    // Held at zero whenever disabled, so it can never wrap on its own.
    always_ff @(posedge clk) begin
        if (rst || i_clear || !i_enable || o_expire) begin
            r_count <= '0;
        end else if (i_tick) begin
            r_count <= r_count + NB_TIMEOUT'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_alu_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_alu_ctrl
// Description : Collects A/B/opcode bytes from UART RX, runs the ALU, sends result.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_alu_ctrl
    import uart_alu_ctrl_pkg::*;
#(
    parameter int NB_DATA       = NB_DATA_DEF,
    parameter int NB_OP         = NB_OP_DEF,
    parameter int NB_TIMEOUT    = NB_TIMEOUT_DEF,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_timeout,
    output logic               o_overrun
);

    state_t             r_state;
    state_t             w_next;
    logic               w_expire;
    logic               w_timeout;
    logic               w_overrun;
    logic [NB_DATA-1:0] r_alu_a;
    logic [NB_DATA-1:0] r_alu_b;
    logic [NB_OP-1:0]   r_alu_op;
    logic               r_tx_start;
    logic [NB_DATA-1:0] r_tx_data;
    logic               r_busy;
    logic               r_timeout;
    logic               r_overrun;

    // Any received byte clears the counter; only the wait states let it run.
    uart_alu_ctrl_tick_timeout #(
        .NB_TIMEOUT    (NB_TIMEOUT),
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_timeout (
        .clk      (i_clk),
        .rst      (i_reset),
        .i_tick   (i_tick),
        .i_clear  (i_rx_done),
        .i_enable (is_wait_state(r_state)),
        .o_expire (w_expire)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        w_overrun = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_rx_done) w_next = S_WAIT_B;
            end
            S_WAIT_B: begin
                if (i_rx_done) begin
                    w_next = S_WAIT_OP;
                end else if (w_expire) begin
                    w_next    = S_IDLE;
                    w_timeout = 1'b1;
                end
            end
            S_WAIT_OP: begin
                if (i_rx_done) begin
                    w_next = S_EXEC;
                end else if (w_expire) begin
                    w_next    = S_IDLE;
                    w_timeout = 1'b1;
                end
            end
            S_EXEC: begin
                w_next    = S_SEND;
                w_overrun = i_rx_done;
            end
            S_SEND: begin
                // tx_done here belongs to no start we issued yet.
                w_next    = S_WAIT_TX;
                w_overrun = i_rx_done;
            end
            S_WAIT_TX: begin
                if (i_tx_done) w_next = S_IDLE;
                w_overrun = i_rx_done;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && i_rx_done)    r_alu_a  <= i_rx_data;
            if (r_state == S_WAIT_B && i_rx_done)  r_alu_b  <= i_rx_data;
            if (r_state == S_WAIT_OP && i_rx_done) r_alu_op <= i_rx_data[NB_OP-1:0];
            if (r_state == S_EXEC)                 r_tx_data <= i_alu_result;
            r_tx_start <= (w_next == S_SEND);
            r_busy     <= (w_next != S_IDLE);
            r_timeout  <= w_timeout;
            r_overrun  <= w_overrun;
        end
    end

    assign o_alu_a    = r_alu_a;
    assign o_alu_b    = r_alu_b;
    assign o_alu_op   = r_alu_op;
    assign o_tx_start = r_tx_start;
    assign o_tx_data  = r_tx_data;
    assign o_busy     = r_busy;
    assign o_timeout  = r_timeout;
    assign o_overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_alu_ctrl
// Description : Self-checking bench for uart_alu_ctrl with a behavioural ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_alu_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] alu_result;
    logic       tx_done = 1'b0;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       timeout;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_model(alu_a, alu_b, alu_op);

    uart_alu_ctrl dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_tick       (tick),
        .i_rx_done    (rx_done),
        .i_rx_data    (rx_data),
        .i_alu_result (alu_result),
        .i_tx_done    (tx_done),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_op     (alu_op),
        .o_tx_start   (tx_start),
        .o_tx_data    (tx_data),
        .o_busy       (busy),
        .o_timeout    (timeout),
        .o_overrun    (overrun)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        step();
        rx_done = 1'b1;
        rx_data = d;
        step();
        rx_done = 1'b0;
    endtask

    task automatic pulse_tick();
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic pulse_tx_done();
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++; if (alu_a !== 8'h00)  begin errors++; $display("FAIL reset_alu_a: got %h want 00", alu_a); end
        checks++; if (alu_b !== 8'h00)  begin errors++; $display("FAIL reset_alu_b: got %h want 00", alu_b); end
        checks++; if (alu_op !== 6'h00) begin errors++; $display("FAIL reset_alu_op: got %h want 00", alu_op); end
        checks++; if ({tx_start, busy, timeout, overrun} !== 4'b0000)
            begin errors++; $display("FAIL reset_flags: got %b want 0000", {tx_start, busy, timeout, overrun}); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        send_byte(8'h05);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_a: got %b want 1", busy); end
        send_byte(8'h03);
        send_byte(8'h20);
        checks++; if (alu_a !== 8'h05)  begin errors++; $display("FAIL basic_alu_a: got %h want 05", alu_a); end
        checks++; if (alu_b !== 8'h03)  begin errors++; $display("FAIL basic_alu_b: got %h want 03", alu_b); end
        checks++; if (alu_op !== 6'h20) begin errors++; $display("FAIL basic_alu_op: got %h want 20", alu_op); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL basic_start_early: got %b want 0", tx_start); end
        step();
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL basic_start_n2: got %b want 1", tx_start); end
        checks++; if (tx_data !== 8'h08) begin errors++; $display("FAIL basic_tx_data: got %h want 08", tx_data); end
        step();
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL basic_start_len: got %b want 0", tx_start); end
        checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL basic_busy_wait: got %b want 1", busy); end
        pulse_tx_done();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b want 0", busy); end
    endtask

    task automatic test_tx_wait();
        int bad = 0;
        logic [7:0] exp = alu_model(8'h9A, 8'h41, 6'h25);
        send_byte(8'h9A);
        send_byte(8'h41);
        send_byte(8'h25);
        step();
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL txw_start: got %b want 1", tx_start); end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL txw_done_in_send: busy got %b want 1", busy); end
        for (int i = 0; i < 1000; i++) begin
            step();
            if (busy !== 1'b1 || tx_start !== 1'b0 || tx_data !== exp) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL txw_hold: bad cycles got %0d want 0", bad); end
        pulse_tx_done();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL txw_idle: got %b want 0", busy); end
    endtask

    task automatic test_timeout();
        send_byte(8'h11);
        repeat (2047) pulse_tick();
        checks++; if ({busy, timeout} !== 2'b10)
            begin errors++; $display("FAIL to_before: busy,timeout got %b want 10", {busy, timeout}); end
        pulse_tick();
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b want 1", timeout); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL to_busy: got %b want 0", busy); end
        checks++; if (alu_a !== 8'h11)  begin errors++; $display("FAIL to_stale_a: got %h want 11", alu_a); end
        step();
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_len: got %b want 0", timeout); end
        pulse_tx_done();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_txdone_idle: got %b want 0", busy); end
        send_byte(8'h40);
        send_byte(8'h02);
        send_byte(8'h22);
        checks++; if (alu_a !== 8'h40) begin errors++; $display("FAIL to_next_a: got %h want 40", alu_a); end
        checks++; if (alu_b !== 8'h02) begin errors++; $display("FAIL to_next_b: got %h want 02", alu_b); end
        step();
        checks++; if (tx_data !== 8'h3E) begin errors++; $display("FAIL to_next_data: got %h want 3e", tx_data); end
        pulse_tx_done();
    endtask

    task automatic test_coincide();
        send_byte(8'h3C);
        repeat (2047) pulse_tick();
        step();
        rx_done = 1'b1;
        rx_data = 8'h66;
        tick    = 1'b1;
        step();
        rx_done = 1'b0;
        tick    = 1'b0;
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL co_timeout: got %b want 0", timeout); end
        checks++; if (alu_b !== 8'h66)  begin errors++; $display("FAIL co_alu_b: got %h want 66", alu_b); end
        checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL co_busy: got %b want 1", busy); end
        repeat (2047) pulse_tick();
        checks++; if ({busy, timeout} !== 2'b10)
            begin errors++; $display("FAIL co_counter_clear: busy,timeout got %b want 10", {busy, timeout}); end
        send_byte(8'hE4);
        checks++; if (alu_op !== 6'h24) begin errors++; $display("FAIL co_op_mask: got %h want 24", alu_op); end
        step();
        checks++; if (tx_data !== 8'h24) begin errors++; $display("FAIL co_tx_data: got %h want 24", tx_data); end
        pulse_tx_done();
    endtask

    task automatic test_overrun();
        send_byte(8'h5A);
        send_byte(8'hC3);
        send_byte(8'h26);
        step();
        step();
        send_byte(8'hFF);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ov_pulse: got %b want 1", overrun); end
        checks++; if ({alu_a, alu_b} !== 16'h5AC3)
            begin errors++; $display("FAIL ov_operands: got %h want 5ac3", {alu_a, alu_b}); end
        checks++; if (alu_op !== 6'h26) begin errors++; $display("FAIL ov_op: got %h want 26", alu_op); end
        checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL ov_busy: got %b want 1", busy); end
        step();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ov_pulse_len: got %b want 0", overrun); end
        checks++; if (tx_data !== 8'h99) begin errors++; $display("FAIL ov_tx_data: got %h want 99", tx_data); end
        pulse_tx_done();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ov_idle: got %b want 0", busy); end
        send_byte(8'h0F);
        send_byte(8'h01);
        send_byte(8'h20);
        send_byte(8'h77);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ov_send_pulse: got %b want 1", overrun); end
        checks++; if (tx_data !== 8'h10) begin errors++; $display("FAIL ov_send_data: got %h want 10", tx_data); end
        checks++; if (alu_a !== 8'h0F)  begin errors++; $display("FAIL ov_send_a: got %h want 0f", alu_a); end
        pulse_tx_done();
    endtask

    task automatic test_reset_mid();
        send_byte(8'hA1);
        send_byte(8'hB2);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if ({alu_a, alu_b, 2'b00, alu_op, tx_data} !== 32'h0)
            begin errors++; $display("FAIL rm_regs: got %h want 0", {alu_a, alu_b, 2'b00, alu_op, tx_data}); end
        checks++; if ({tx_start, busy, timeout, overrun} !== 4'b0000)
            begin errors++; $display("FAIL rm_flags: got %b want 0000", {tx_start, busy, timeout, overrun}); end
        send_byte(8'h07);
        send_byte(8'h09);
        send_byte(8'h20);
        step();
        checks++; if ({tx_start, tx_data} !== 9'h110)
            begin errors++; $display("FAIL rm_next_frame: got %h want 110", {tx_start, tx_data}); end
        pulse_tx_done();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_idle: got %b want 0", busy); end
    endtask

    task automatic test_random_frames();
        logic [5:0] ops [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};
        int stray = 0;
        for (int f = 0; f < 25; f++) begin
            logic [7:0] a   = 8'($urandom);
            logic [7:0] b   = 8'($urandom);
            logic [5:0] op  = ops[$urandom_range(0, 5)];
            logic [7:0] opb = {2'($urandom), op};
            logic [7:0] exp = alu_model(a, b, op);
            send_byte(a);
            repeat ($urandom_range(0, 6)) begin
                pulse_tick();
                if (timeout !== 1'b0) stray++;
            end
            send_byte(b);
            repeat ($urandom_range(0, 6)) step();
            send_byte(opb);
            checks++; if ({alu_a, alu_b, alu_op} !== {a, b, op})
                begin errors++; $display("FAIL rnd_operands[%0d]: got %h want %h", f, {alu_a, alu_b, alu_op}, {a, b, op}); end
            step();
            checks++; if ({tx_start, tx_data} !== {1'b1, exp})
                begin errors++; $display("FAIL rnd_result[%0d]: got %h want %h", f, {tx_start, tx_data}, {1'b1, exp}); end
            repeat ($urandom_range(0, 10)) step();
            pulse_tx_done();
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_idle[%0d]: got %b want 0", f, busy); end
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL rnd_stray_timeout: got %0d want 0", stray); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tx_wait();
        test_timeout();
        test_coincide();
        test_overrun();
        test_reset_mid();
        test_random_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
